// File: rtl/bus_sync_mc.sv
// rtl/bus_sync_mc.sv - multi-channel enable-qualified bus synchronizer with valid/ready hand-off
//
// Purpose:
//   Moves NUM_CH independent BUS_WIDTH-bit words into the clk domain. Each
//   channel carries its source event on bus_enable[c]. That line passes through
//   a NUM_STAGES-deep synchronizer and then one history flop. A detected event
//   captures the channel's slice of unsync_bus straight into sync_bus. The
//   data bus is deliberately not synchronized: the source holds it stable
//   long enough for the capture to see settled data.
//
// Parameters:
//   NUM_STAGES  - synchronizer depth, 2 or more
//   BUS_WIDTH   - data bits per channel
//   NUM_CH      - number of independent channels
//   TOGGLE_MODE - 0: rising edge of enable is an event, 1: any enable edge
//
// Ports:
//   clk          in   destination clock, rising edge
//   reset        in   asynchronous active-low reset
//   unsync_bus   in   source data, channel c at [c*BUS_WIDTH +: BUS_WIDTH]
//   bus_enable   in   per-channel source event line
//   sync_ready   in   per-channel consumer ready, ignored while sync_valid is 0
//   ovf_clr      in   clears every overflow flag (and drop counter)
//   sync_bus     out  captured data, packed like unsync_bus
//   sync_valid   out  per-channel captured-data-valid flag
//   enable_pulse out  one-cycle pulse per accepted capture
//   overflow     out  sticky per-channel dropped-event flag
//   drop_cnt     out  per-channel 8-bit saturating drop counters
//                     (present only with BUS_SYNC_MC_DROP_CNT_EN)
//
// Build option:
//   BUS_SYNC_MC_DROP_CNT_EN - adds the drop_cnt port and its counters

module bus_sync_mc #(
    parameter int NUM_STAGES  = 2,
    parameter int BUS_WIDTH   = 8,
    parameter int NUM_CH      = 4,
    parameter int TOGGLE_MODE = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CH*BUS_WIDTH-1:0]   unsync_bus,
    input  logic [NUM_CH-1:0]             bus_enable,
    input  logic [NUM_CH-1:0]             sync_ready,
    input  logic                          ovf_clr,
    output logic [NUM_CH*BUS_WIDTH-1:0]   sync_bus,
    output logic [NUM_CH-1:0]             sync_valid,
    output logic [NUM_CH-1:0]             enable_pulse,
    output logic [NUM_CH-1:0]             overflow
`ifdef BUS_SYNC_MC_DROP_CNT_EN
    ,
    output logic [NUM_CH*8-1:0]           drop_cnt
`endif
);

    // After reset the synchronizer and history flops are all 0. In toggle mode,
    // an enable that is held high would therefore look like an edge. The fill
    // counter keeps toggle detection disarmed until the history flop has seen a
    // fully refilled pipeline (NUM_STAGES + 1 edges). Rising-edge mode ignores it.
    // In that mode, a held-high enable after reset is reported as a fresh event.
    localparam int FILL_MAX = NUM_STAGES + 1;
    localparam int FILL_W   = $clog2(NUM_STAGES + 2);

    logic [NUM_STAGES-1:0]          r_sync [NUM_CH];
    logic [NUM_CH-1:0]              r_hist;
    logic [FILL_W-1:0]              r_fill;
    logic [NUM_CH*BUS_WIDTH-1:0]    r_bus;
    logic [NUM_CH-1:0]              r_valid;
    logic [NUM_CH-1:0]              r_pulse;
    logic [NUM_CH-1:0]              r_ovf;

    logic                           w_armed;
    logic [NUM_CH-1:0]              w_last;
    logic [NUM_CH-1:0]              w_event;
    logic [NUM_CH-1:0]              w_accept;
    logic [NUM_CH-1:0]              w_drop;
    logic [NUM_CH-1:0]              w_release;

    assign w_armed = (r_fill == FILL_W'(FILL_MAX));

    always_comb begin
        w_last    = '0;
        w_event   = '0;
        w_accept  = '0;
        w_drop    = '0;
        w_release = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_last[c] = r_sync[c][NUM_STAGES-1];
            if (TOGGLE_MODE != 0) begin
                w_event[c] = w_armed & (w_last[c] ^ r_hist[c]);
            end else begin
                w_event[c] = w_last[c] & ~r_hist[c];
            end
            // A consumer taking the old word on the same edge frees the slot,
            // so the new event is accepted instead of dropped.
            w_accept[c]  = w_event[c] & (~r_valid[c] | sync_ready[c]);
            w_drop[c]    = w_event[c] & r_valid[c] & ~sync_ready[c];
            w_release[c] = ~w_event[c] & r_valid[c] & sync_ready[c];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_sync[c] <= '0;
            end
            r_hist  <= '0;
            r_fill  <= '0;
            r_bus   <= '0;
            r_valid <= '0;
            r_pulse <= '0;
            r_ovf   <= '0;
        end else begin
            if (r_fill != FILL_W'(FILL_MAX)) begin
                r_fill <= r_fill + FILL_W'(1);
            end
            for (int c = 0; c < NUM_CH; c++) begin
                r_sync[c] <= {r_sync[c][NUM_STAGES-2:0], bus_enable[c]};
            end
            r_hist  <= w_last;
            r_pulse <= w_accept;
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_accept[c]) begin
                    r_bus[c*BUS_WIDTH +: BUS_WIDTH] <= unsync_bus[c*BUS_WIDTH +: BUS_WIDTH];
                    r_valid[c]                      <= 1'b1;
                end else if (w_release[c]) begin
                    // sync_bus keeps the last word after the consumer takes it
                    r_valid[c] <= 1'b0;
                end
            end
            // A drop on the same edge as a clear leaves the flag set.
            r_ovf <= w_drop | (r_ovf & ~{NUM_CH{ovf_clr}});
        end
    end

    assign sync_bus     = r_bus;
    assign sync_valid   = r_valid;
    assign enable_pulse = r_pulse;
    assign overflow     = r_ovf;

`ifdef BUS_SYNC_MC_DROP_CNT_EN
    logic [NUM_CH*8-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_drop[c]) begin
                    // Saturate at 255. A drop beats a simultaneous clear, as the flag does.
                    if (r_cnt[c*8 +: 8] != 8'hFF) begin
                        r_cnt[c*8 +: 8] <= r_cnt[c*8 +: 8] + 8'd1;
                    end
                end else if (ovf_clr) begin
                    r_cnt[c*8 +: 8] <= 8'd0;
                end
            end
        end
    end

    assign drop_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_bus_sync_mc.sv
// tb/tb_bus_sync_mc.sv - self-checking bench for bus_sync_mc, rising-edge and toggle instances side by side
module tb_bus_sync_mc;

    localparam int NS  = 2;
    localparam int W   = 8;
    localparam int NCH = 4;

    logic               clk;
    logic               reset;
    logic [NCH*W-1:0]   unsync_bus;
    logic [NCH-1:0]     bus_enable;
    logic [NCH-1:0]     sync_ready;
    logic               ovf_clr;

    logic [NCH*W-1:0]   sb [2];
    logic [NCH-1:0]     sv [2];
    logic [NCH-1:0]     ep [2];
    logic [NCH-1:0]     ov [2];
`ifdef BUS_SYNC_MC_DROP_CNT_EN
    logic [NCH*8-1:0]   dc [2];
`endif

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bus_sync_mc #(.NUM_STAGES(NS), .BUS_WIDTH(W), .NUM_CH(NCH), .TOGGLE_MODE(0)) u_rise (
        .clk          (clk),
        .reset        (reset),
        .unsync_bus   (unsync_bus),
        .bus_enable   (bus_enable),
        .sync_ready   (sync_ready),
        .ovf_clr      (ovf_clr),
        .sync_bus     (sb[0]),
        .sync_valid   (sv[0]),
        .enable_pulse (ep[0]),
        .overflow     (ov[0])
`ifdef BUS_SYNC_MC_DROP_CNT_EN
        ,
        .drop_cnt     (dc[0])
`endif
    );

    bus_sync_mc #(.NUM_STAGES(NS), .BUS_WIDTH(W), .NUM_CH(NCH), .TOGGLE_MODE(1)) u_tog (
        .clk          (clk),
        .reset        (reset),
        .unsync_bus   (unsync_bus),
        .bus_enable   (bus_enable),
        .sync_ready   (sync_ready),
        .ovf_clr      (ovf_clr),
        .sync_bus     (sb[1]),
        .sync_valid   (sv[1]),
        .enable_pulse (ep[1]),
        .overflow     (ov[1])
`ifdef BUS_SYNC_MC_DROP_CNT_EN
        ,
        .drop_cnt     (dc[1])
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. Index 0 is rising-edge mode and index 1 is toggle mode.
    // The enable level sampled at each post-reset edge is kept in a queue. The
    // decision at edge m looks at the samples taken NS and NS+1 edges earlier.
    // Samples from before reset count as 0. In toggle mode, both samples must
    // come from after reset.
    logic [W-1:0]   m_bus   [2][NCH];
    logic [NCH-1:0] m_valid [2];
    logic [NCH-1:0] m_pulse [2];
    logic [NCH-1:0] m_ovf   [2];
    int             m_cnt   [2][NCH];
    logic [NCH-1:0] en_q [$];
    logic           model_ok = 1'b0;

    always @(posedge clk or negedge reset) begin : model
        int             m;
        logic [NCH-1:0] s_cur;
        logic [NCH-1:0] s_prv;
        logic           ev;
        logic           drop;
        if (!reset) begin
            en_q.delete();
            for (int t = 0; t < 2; t++) begin
                m_valid[t] = '0;
                m_pulse[t] = '0;
                m_ovf[t]   = '0;
                for (int c = 0; c < NCH; c++) begin
                    m_bus[t][c] = '0;
                    m_cnt[t][c] = 0;
                end
            end
            model_ok = 1'b1;
        end else begin
            en_q.push_back(bus_enable);
            m     = en_q.size();
            s_cur = '0;
            s_prv = '0;
            if (m - NS >= 1)     s_cur = en_q[m-NS-1];
            if (m - NS - 1 >= 1) s_prv = en_q[m-NS-2];
            for (int t = 0; t < 2; t++) begin
                for (int c = 0; c < NCH; c++) begin
                    if (t == 0) ev = s_cur[c] && !s_prv[c];
                    else        ev = (m >= NS + 2) && (s_cur[c] != s_prv[c]);
                    drop = ev && m_valid[t][c] && !sync_ready[c];
                    m_pulse[t][c] = ev && !drop;
                    if (ev && !drop) begin
                        m_bus[t][c]   = unsync_bus[c*W +: W];
                        m_valid[t][c] = 1'b1;
                    end else if (!ev && m_valid[t][c] && sync_ready[c]) begin
                        m_valid[t][c] = 1'b0;
                    end
                    if (drop)         m_ovf[t][c] = 1'b1;
                    else if (ovf_clr) m_ovf[t][c] = 1'b0;
                    if (drop) begin
                        if (m_cnt[t][c] < 255) m_cnt[t][c]++;
                    end else if (ovf_clr) begin
                        m_cnt[t][c] = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [NCH*W-1:0] eb;
        logic [NCH*8-1:0] ec;
        if (model_ok) begin
            for (int t = 0; t < 2; t++) begin
                for (int c = 0; c < NCH; c++) begin
                    eb[c*W +: W] = m_bus[t][c];
                    ec[c*8 +: 8] = 8'(m_cnt[t][c]);
                end
                chk($sformatf("cyc_m%0d_sync_bus", t),     sb[t], eb);
                chk($sformatf("cyc_m%0d_sync_valid", t),   sv[t], m_valid[t]);
                chk($sformatf("cyc_m%0d_enable_pulse", t), ep[t], m_pulse[t]);
                chk($sformatf("cyc_m%0d_overflow", t),     ov[t], m_ovf[t]);
`ifdef BUS_SYNC_MC_DROP_CNT_EN
                chk($sformatf("cyc_m%0d_drop_cnt", t),     dc[t], ec);
`endif
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_data(input int c, input logic [7:0] d);
        unsync_bus[c*W +: W] = d;
    endtask

    initial begin : stim
        int pc0;
        int pc1;
        reset      = 1'b0;
        unsync_bus = '0;
        bus_enable = '0;
        sync_ready = '0;
        ovf_clr    = 1'b0;
        step(3);
        for (int t = 0; t < 2; t++) begin
            chk($sformatf("rst_m%0d_bus", t),   sb[t], 0);
            chk($sformatf("rst_m%0d_valid", t), sv[t], 0);
            chk($sformatf("rst_m%0d_pulse", t), ep[t], 0);
            chk($sformatf("rst_m%0d_ovf", t),   ov[t], 0);
        end
        reset = 1'b1;
        step(6);

        // basic latency, channel 0
        set_data(0, 8'hA5);
        bus_enable[0] = 1'b1;
        step(2);
        chk("lat_e2_valid", sv[0][0], 0);
        step(1);
        for (int t = 0; t < 2; t++) begin
            chk($sformatf("lat_e3_m%0d_data", t),  sb[t][7:0], 8'hA5);
            chk($sformatf("lat_e3_m%0d_valid", t), sv[t][0], 1);
            chk($sformatf("lat_e3_m%0d_pulse", t), ep[t][0], 1);
        end
        step(1);
        chk("lat_e4_pulse", ep[0][0], 0);
        sync_ready[0] = 1'b1;
        step(1);
        chk("release_valid", sv[0][0], 0);
        chk("release_hold",  sb[0][7:0], 8'hA5);
        sync_ready[0] = 1'b0;

        // backpressure, channel 1
        set_data(1, 8'h11);
        bus_enable[1] = 1'b1;
        step(4);
        chk("bp_first_valid", sv[0][1], 1);
        set_data(1, 8'h3C);
        bus_enable[1] = 1'b0;
        step(4);
        bus_enable[1] = 1'b1;
        step(3);
        chk("bp_data_kept", sb[0][15:8], 8'h11);
        chk("bp_ovf",       ov[0][1], 1);
        chk("bp_no_pulse",  ep[0][1], 0);
        chk("bp_tog_ovf",   ov[1][1], 1);
`ifdef BUS_SYNC_MC_DROP_CNT_EN
        chk("bp_cnt",     dc[0][15:8], 8'd1);
        chk("bp_tog_cnt", dc[1][15:8], 8'd2);
`endif

        // accept and new event on the same edge, channel 2
        set_data(2, 8'h55);
        bus_enable[2] = 1'b1;
        step(4);
        chk("acc_first_valid", sv[0][2], 1);
        bus_enable[2] = 1'b0;
        step(4);
        set_data(2, 8'h77);
        bus_enable[2] = 1'b1;
        step(2);
        sync_ready[2] = 1'b1;
        step(1);
        chk("acc_data",  sb[0][23:16], 8'h77);
        chk("acc_valid", sv[0][2], 1);
        chk("acc_pulse", ep[0][2], 1);
        chk("acc_ovf",   ov[0][2], 0);
        sync_ready[2] = 1'b0;
        step(1);
        chk("acc_one_pulse", ep[0][2], 0);

        // toggle mode vs rising mode, channel 3, edges 10 cycles apart
        sync_ready[3] = 1'b1;
        pc0 = 0;
        pc1 = 0;
        set_data(3, 8'h33);
        bus_enable[3] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (ep[0][3]) pc0++;
            if (ep[1][3]) pc1++;
        end
        set_data(3, 8'h44);
        bus_enable[3] = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ep[0][3]) pc0++;
            if (ep[1][3]) pc1++;
        end
        chk("tog_rise_pulses", 64'(pc0), 1);
        chk("tog_any_pulses",  64'(pc1), 2);
        chk("tog_rise_data",   sb[0][31:24], 8'h33);
        chk("tog_any_data",    sb[1][31:24], 8'h44);

        // all channels on the same edge
        bus_enable = '0;
        sync_ready = 4'hF;
        step(5);
        unsync_bus = 32'h0804_0201;
        bus_enable = 4'hF;
        step(3);
        for (int t = 0; t < 2; t++) begin
            chk($sformatf("all_m%0d_bus", t),   sb[t], 32'h0804_0201);
            chk($sformatf("all_m%0d_pulse", t), ep[t], 4'hF);
        end
        chk("all_model_ch3", m_bus[0][3], 8'h08);

        // reset during synchronization
        sync_ready = '0;
        step(2);
        bus_enable = '0;
        step(4);
        unsync_bus = 32'hDEAD_BEEF;
        bus_enable = 4'hF;
        step(1);
        #2 reset = 1'b0;
        #1;
        for (int t = 0; t < 2; t++) begin
            chk($sformatf("mid_rst_m%0d_bus", t),   sb[t], 0);
            chk($sformatf("mid_rst_m%0d_valid", t), sv[t], 0);
            chk($sformatf("mid_rst_m%0d_pulse", t), ep[t], 0);
            chk($sformatf("mid_rst_m%0d_ovf", t),   ov[t], 0);
`ifdef BUS_SYNC_MC_DROP_CNT_EN
            chk($sformatf("mid_rst_m%0d_cnt", t),   dc[t], 0);
`endif
        end
        step(2);
        reset = 1'b1;
        step(6);
        chk("post_rst_rise_valid", sv[0], 4'hF);
        chk("post_rst_rise_bus",   sb[0], 32'hDEAD_BEEF);
        chk("post_rst_tog_valid",  sv[1], 4'h0);

        // 300 drops on channel 0, then clear
        repeat (300) begin
            bus_enable[0] = 1'b0;
            step(2);
            bus_enable[0] = 1'b1;
            step(2);
        end
        step(4);
        chk("drops_ovf", ov[0][0], 1);
`ifdef BUS_SYNC_MC_DROP_CNT_EN
        chk("drops_cnt_sat",     dc[0][7:0], 8'd255);
        chk("drops_tog_cnt_sat", dc[1][7:0], 8'd255);
`endif
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        for (int t = 0; t < 2; t++) begin
            chk($sformatf("clr_m%0d_ovf", t), ov[t], 0);
`ifdef BUS_SYNC_MC_DROP_CNT_EN
            chk($sformatf("clr_m%0d_cnt", t), dc[t], 0);
`endif
        end
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
